// File: rtl/mmio_uart_responder.sv
// rtl/mmio_uart_responder.sv - MMIO UART TX FIFO/serializer, synchronized input port and baud divisor
// Read data is combinational so it can be muxed against data RAM in the same MEM cycle.
module mmio_uart_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0100,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [7:0]  PortIn,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic        TxD,
  output logic        TxBusy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t      state_q;
  logic [15:0] div_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        txd_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;

  logic [15:0] baud_q;
  logic        ovf_q;
  logic        chg_q;
  logic [7:0]  sync1_q, sync2_q, prev_q;

  logic       wr_hit, rd_hit;
  logic [1:0] off;
  logic       full, empty;
  logic       push_req, push, pop;
  logic [7:0] head_data;
  logic [31:0] status;
  logic       unused_bits;

  assign Hit    = (Address[31:4] == BASE_ADDR[31:4]) && (MemRead || MemWrite);
  assign wr_hit = Hit && MemWrite;
  assign rd_hit = Hit && MemRead;
  assign off    = Address[3:2];
  assign unused_bits = ^{Address[1:0], WriteData[31:16]};

  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign push_req  = wr_hit && (off == 2'd0);
  assign push      = push_req && !full;
  assign head_data = mem_q[head_q];

  // The serializer takes the head whenever a frame can start: from idle, or at the last stop-bit cycle.
  assign pop = !empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && (div_q == 16'd0)));

  assign TxD    = txd_q;
  assign TxBusy = (state_q != S_IDLE) || !empty;

  assign status = {16'd0, 8'(count_q), 3'd0, ovf_q, chg_q, empty, full, TxBusy};

  always_comb begin
    ReadData = 32'd0;
    if (rd_hit) begin
      case (off)
        2'd1:    ReadData = status;
        2'd2:    ReadData = {24'd0, sync2_q};
        2'd3:    ReadData = {16'd0, baud_q};
        default: ReadData = 32'd0;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= WriteData[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_q <= DEFAULT_DIV;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_hit && (off == 2'd3)) baud_q <= WriteData[15:0];
      if (push_req && full)                 ovf_q <= 1'b1;
      else if (wr_hit && (off == 2'd1))     ovf_q <= 1'b0;
    end
  end

  // A new change edge beats a simultaneous PORTIN read so no transition is ever lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 8'd0;
      sync2_q <= 8'd0;
      prev_q  <= 8'd0;
      chg_q   <= 1'b0;
    end else begin
      sync1_q <= PortIn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (sync2_q != prev_q)              chg_q <= 1'b1;
      else if (rd_hit && (off == 2'd2))   chg_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      txd_q   <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          txd_q <= 1'b1;
          if (pop) begin
            shift_q <= head_data;
            div_q   <= baud_q;
            txd_q   <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (div_q == 16'd0) begin
            div_q   <= baud_q;
            bit_q   <= 3'd0;
            txd_q   <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            div_q <= div_q - 16'd1;
          end
        end
        S_DATA: begin
          if (div_q == 16'd0) begin
            div_q <= baud_q;
            if (bit_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= S_STOP;
            end else begin
              shift_q <= {1'b0, shift_q[7:1]};
              txd_q   <= shift_q[1];
              bit_q   <= bit_q + 3'd1;
            end
          end else begin
            div_q <= div_q - 16'd1;
          end
        end
        S_STOP: begin
          if (div_q == 16'd0) begin
            if (pop) begin
              shift_q <= head_data;
              div_q   <= baud_q;
              txd_q   <= 1'b0;
              state_q <= S_START;
            end else begin
              txd_q   <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            div_q <= div_q - 16'd1;
          end
        end
        default: begin
          txd_q   <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_responder.sv
// tb/tb_mmio_uart_responder.sv - directed self-checking bench for mmio_uart_responder
module tb_mmio_uart_responder;

  localparam logic [31:0] A_TX = 32'h1001_0100;
  localparam logic [31:0] A_ST = 32'h1001_0104;
  localparam logic [31:0] A_PI = 32'h1001_0108;
  localparam logic [31:0] A_BD = 32'h1001_010C;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address, WriteData;
  logic        MemWrite, MemRead;
  logic [7:0]  PortIn;
  logic [31:0] ReadData;
  logic        Hit, TxD, TxBusy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [63:0] hist = '0;

  mmio_uart_responder dut (
    .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .PortIn(PortIn),
    .ReadData(ReadData), .Hit(Hit), .TxD(TxD), .TxBusy(TxBusy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) hist <= {hist[62:0], TxD};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    Address = a; WriteData = d; MemWrite = 1'b1;
    @(posedge clk); #1;
    MemWrite = 1'b0; Address = 32'd0; WriteData = 32'd0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    @(negedge clk);
    Address = a; MemRead = 1'b1;
    #1 d = ReadData;
    check(tag, d, exp);
    @(posedge clk); #1;
    MemRead = 1'b0; Address = 32'd0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (TxBusy && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check(tag, {63'd0, TxBusy}, 64'd0);
  endtask

  initial begin
    int e;
    logic [63:0] exp_bits;
    logic [9:0]  frame;
    logic [7:0]  bytes [3];

    reset = 1'b1; Address = 32'd0; WriteData = 32'd0;
    MemWrite = 1'b0; MemRead = 1'b0; PortIn = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1;
    check("rst_hit", {63'd0, Hit}, 64'd0);
    check("rst_rdata", {32'd0, ReadData}, 64'd0);
    check("rst_txd", {63'd0, TxD}, 64'd1);
    check("rst_busy", {63'd0, TxBusy}, 64'd0);
    rd_chk("rst_status", A_ST, 32'h0000_0004);
    rd_chk("rst_baud", A_BD, 32'd433);

    @(negedge clk); Address = A_ST; MemRead = 1'b1;
    #1 check("hit_in_window", {63'd0, Hit}, 64'd1);
    MemRead = 1'b0; Address = 32'd0;

    // 0x55 at 4 cycles per bit
    wr(A_BD, 32'hFFFF_0003);
    rd_chk("baud_rw", A_BD, 32'h0000_0003);
    wr(A_TX, 32'h0000_0055);
    e = cyc;
    wait_cyc(e + 40);
    @(negedge clk); #1;
    exp_bits = '0;
    frame = {1'b0, 8'h55 >> 0, 1'b1};
    frame = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 9; k >= 0; k--)
      for (int r = 0; r < 4; r++)
        exp_bits = {exp_bits[62:0], frame[k]};
    check("frame_55", {24'd0, hist[39:0]}, exp_bits);
    check("busy_stop_end", {63'd0, TxBusy}, 64'd1);
    @(negedge clk); #1;
    check("busy_after_frame", {63'd0, TxBusy}, 64'd0);

    // three back-to-back frames at 1 cycle per bit
    wr(A_BD, 32'd0);
    bytes[0] = 8'hA1; bytes[1] = 8'h02; bytes[2] = 8'h03;
    wr(A_TX, {24'd0, bytes[0]});
    e = cyc;
    wr(A_TX, {24'd0, bytes[1]});
    wr(A_TX, {24'd0, bytes[2]});
    rd_chk("status_count2", A_ST, 32'h0000_0201);
    wait_cyc(e + 30);
    @(negedge clk); #1;
    exp_bits = '0;
    for (int f = 0; f < 3; f++) begin
      exp_bits = {exp_bits[62:0], 1'b0};
      for (int b = 0; b < 8; b++) exp_bits = {exp_bits[62:0], bytes[f][b]};
      exp_bits = {exp_bits[62:0], 1'b1};
    end
    check("frames_b2b", {34'd0, hist[29:0]}, exp_bits);
    wait_idle("idle_after_b2b");

    // overflow: one byte in flight, eight buffered, tenth dropped
    wr(A_BD, 32'd1000);
    for (int i = 0; i < 10; i++) wr(A_TX, i);
    rd_chk("status_full_ovf", A_ST, 32'h0000_0813);
    wr(A_ST, 32'hFFFF_FFFF);
    rd_chk("status_ovf_clr", A_ST, 32'h0000_0803);

    @(negedge clk); #2 reset = 1'b1;
    #1;
    check("rst_async_txd", {63'd0, TxD}, 64'd1);
    check("rst_async_busy", {63'd0, TxBusy}, 64'd0);
    rd_chk("rst_async_status", A_ST, 32'h0000_0004);
    rd_chk("rst_async_baud", A_BD, 32'd433);
    @(negedge clk); reset = 1'b0;

    // input port change detection
    @(negedge clk); PortIn = 8'h3C;
    repeat (3) @(posedge clk);
    #1;
    rd_chk("chg_set", A_ST, 32'h0000_000C);
    rd_chk("portin_val", A_PI, 32'h0000_003C);
    rd_chk("chg_cleared", A_ST, 32'h0000_0004);
    @(negedge clk); PortIn = 8'h5A; Address = A_PI; MemRead = 1'b1;
    repeat (3) @(posedge clk);
    #1 MemRead = 1'b0; Address = 32'd0;
    rd_chk("chg_set_wins", A_ST, 32'h0000_000C);
    rd_chk("portin_val2", A_PI, 32'h0000_005A);
    @(negedge clk); PortIn = 8'h00;

    // reset during data bit 4 of 0x0F with a second byte queued
    wr(A_BD, 32'd3);
    wr(A_TX, 32'h0000_000F);
    e = cyc;
    wr(A_TX, 32'h0000_0081);
    wait_cyc(e + 22);
    @(negedge clk); #1;
    check("mid_bit4_txd", {63'd0, TxD}, 64'd0);
    check("mid_bit4_busy", {63'd0, TxBusy}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_txd", {63'd0, TxD}, 64'd1);
    check("mid_rst_busy", {63'd0, TxBusy}, 64'd0);
    @(negedge clk); reset = 1'b0;
    rd_chk("mid_rst_status", A_ST, 32'h0000_0004);
    repeat (20) @(negedge clk);
    #1;
    check("no_partial_frame", {44'd0, hist[19:0]}, {44'd0, 20'hFFFFF});

    // outside the window
    @(negedge clk); Address = 32'h1001_0110; MemRead = 1'b1;
    #1;
    check("oow_hit", {63'd0, Hit}, 64'd0);
    check("oow_rdata", {32'd0, ReadData}, 64'd0);
    MemRead = 1'b0;
    wr(32'h1001_0110, 32'h0000_0041);
    rd_chk("oow_no_push", A_ST, 32'h0000_0004);
    check("oow_txd", {63'd0, TxD}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_uart_responder.md
Name: mmio_uart_responder

Overview:
- Memory-mapped peripheral that responds to the processor's MEM-stage data bus (Address, WriteData, MemWrite, MemRead), in parallel with the data RAM.
- Provides:
  - a TX FIFO feeding an 8N1 UART serializer,
  - a synchronized, change-flagged 8-bit input port,
  - a programmable baud divisor.
- Read data is combinational, so the processor's MEM-stage timing is unchanged. The top level muxes ReadData against RAM using Hit.

Parameters:
- BASE_ADDR, 32'h1001_0100, 16-byte-aligned base of the register block.
- FIFO_DEPTH, 8, TX FIFO entries; power of 2, range 2..128.
- DEFAULT_DIV, 433, reset value of BAUDDIV; bit period = BAUDDIV+1 clk cycles.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- Address  input  32  byte address from EX/MEM ALU result
- WriteData  input  32  store data
- MemWrite  input  1  store strobe, one cycle per store
- MemRead  input  1  load strobe
- PortIn  input  8  asynchronous external input port
- ReadData  output  32  load data; combinational
- Hit  output  1  Address[31:4]==BASE_ADDR[31:4] and (MemRead or MemWrite)
- TxD  output  1  UART serial out, idle high
- TxBusy  output  1  serializer not in IDLE, or FIFO not empty

Behaviour:
- Register map (offset = Address[3:0]; Address[1:0] ignored):
  - 0x0 TXDATA
    - W: push WriteData[7:0] into FIFO.
    - R: 0.
  - 0x4 STATUS
    - R: bit0 TxBusy, bit1 full, bit2 empty, bit3 in_changed, bit4 overflow, [15:8] FIFO count, rest 0.
    - W (any value): clears overflow.
  - 0x8 PORTIN
    - R: {24'b0, port_sync}; the read clears in_changed.
    - W: ignored.
  - 0xC BAUDDIV
    - R/W: [15:0]; upper bits read 0.
- Reads:
  - ReadData = selected register when Hit and MemRead.
  - ReadData = 0 otherwise.
  - Read side effects (clearing in_changed) apply at the clock edge.
- Writes: take effect at the rising edge where MemWrite and Hit are high.
- FIFO:
  - Circular buffer with head/tail pointers and a count of width log2(FIFO_DEPTH)+1.
  - Full/empty are derived from the registered count.
  - Push while full: data dropped, overflow set (sticky).
  - Push while full in the same cycle as a pop: still dropped; full is evaluated before the pop.
  - Push and pop in the same cycle when not full: count is unchanged and both pointers advance.
- Serializer FSM: IDLE, START, DATA, STOP. Bit counter is 3 bits; divider counter is 16 bits.
  - IDLE: TxD=1. If FIFO not empty: pop the head into the shift register, load divider=BAUDDIV, go to START.
  - START: TxD=0 for BAUDDIV+1 cycles, then go to DATA with bit index 0.
  - DATA: TxD=shift[0], LSB first. Each bit lasts BAUDDIV+1 cycles; shift right and increment the index after each bit. After bit 7 go to STOP.
  - STOP: TxD=1 for BAUDDIV+1 cycles. Then go to START if the FIFO is non-empty (popping in the same cycle, back-to-back with no idle gap); otherwise go to IDLE.
- Latency: for a TXDATA write at edge E into an empty FIFO with the FSM in IDLE, the pop happens and TxD falls at edge E+1. A frame is 10*(BAUDDIV+1) cycles.
- BAUDDIV writes are sampled only at each bit-period load, so an in-flight bit keeps its length. BAUDDIV=0 gives 1 cycle per bit.
- PortIn:
  - Two-flop synchronizer, then a third register prev.
  - in_changed sets when sync2 != prev.
  - If the set and a PORTIN read-clear happen in the same cycle, the set wins.
- Reset, asynchronous at any time including mid-frame:
  - FSM to IDLE; FIFO emptied; TxD=1; TxBusy=0.
  - BAUDDIV=DEFAULT_DIV.
  - overflow=0, in_changed=0, synchronizer/prev=0.
  - ReadData=0 and Hit=0 given idle bus inputs.
- An access outside the 16-byte window has no effect; Hit=0 and ReadData=0.

Test Plan:
- Reset, then read STATUS at 0x1001_0104 -> 0x0000_0004 (empty); TxD=1; read BAUDDIV -> 433.
- Write BAUDDIV=3, then write TXDATA=0x55 at edge E. From E+1, TxD must show, 4 cycles per bit:
  - 0 (start),
  - data 1,0,1,0,1,0,1,0,
  - 1 (stop).
  - Total 40 cycles, then TxBusy=0.
- With BAUDDIV=0, write 0xA1, 0x02, 0x03 on consecutive cycles -> three back-to-back 10-cycle frames with no idle bit between them. STATUS[15:8] reads 2 on the cycle after the third write.
- With BAUDDIV=1000, push 10 bytes -> the first pops immediately and 8 are buffered. The 10th push sets overflow; STATUS reads full=1, bit4=1, count 8. Writing STATUS clears bit4 only.
- Change PortIn 0x00->0x3C -> in_changed=1 within 3 cycles; PORTIN reads 0x3C; the next STATUS read shows bit3=0. Change PortIn again in the same cycle as a PORTIN read -> bit3 stays 1.
- Assert reset mid-DATA bit 4 -> TxD=1 and FIFO empty immediately, with no completion of the partial frame. Access to 0x1001_0110 -> Hit=0, ReadData=0.
